// File: rtl/seg_led_apb.sv
// seg_led_apb: APB register block driving a six-digit, common-anode,
// multiplexed seven-segment display.
//
// Optional feature macro: SEG_LED_DP_EN
// - When defined, DIGITn bit[4] drives the decimal point.
// - When undefined, the dp segment is always off and DIGITn keeps only bits[3:0].
//
// The reset input is named rst_n but is active-high and synchronous.
// The name is kept to match the SoC port list.
module seg_led_apb #(
    parameter int SCAN_DIV = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic [4:0]  paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic [5:0]  seg_sel_n,
    output logic [7:0]  seg_data
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
`ifdef SEG_LED_DP_EN
    localparam int DW = 8;
`else
    localparam int DW = 4;
`endif

    logic [DW-1:0]    digit [6];
    logic             ctrl;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic             wr_en;
    logic [DW-1:0]    cur;
    logic             cur_dp;
    logic             unused_bits;

    assign wr_en = psel & penable & pwrite;
    assign cur   = digit[idx];

`ifdef SEG_LED_DP_EN
    assign cur_dp      = cur[4];
    assign unused_bits = ^{pwdata[31:DW], cur[7:5]};
`else
    assign cur_dp      = 1'b0;
    assign unused_bits = ^pwdata[31:DW];
`endif

    // Active-high {g,f,e,d,c,b,a} pattern for one hex digit
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
            4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
            4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
            4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
        endcase
        return p;
    endfunction

    // Register file writes; reserved indices are silently dropped
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 6; i++) digit[i] <= '0;
            ctrl <= 1'b0;
        end else if (wr_en) begin
            if (paddr < 5'd6)
                digit[paddr[2:0]] <= pwdata[DW-1:0];
            else if (paddr == 5'd6)
                ctrl <= pwdata[0];
        end
    end

    // Zero-wait-state read mux, zero outside a read
    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            if (paddr < 5'd6)
                prdata[DW-1:0] = digit[paddr[2:0]];
            else if (paddr == 5'd6)
                prdata[0] = ctrl;
        end
    end

    // Dwell counter and digit index; both parked at 0 while scanning is off
    always_ff @(posedge clk) begin
        if (rst_n || !ctrl) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered display drive so segments and select change on the same edge
    always_ff @(posedge clk) begin
        if (rst_n || !ctrl) begin
            seg_sel_n <= 6'b111111;
            seg_data  <= 8'hFF;
        end else begin
            seg_sel_n <= ~(6'b000001 << idx);
            seg_data  <= ~{cur_dp, hex_decode(cur[3:0])};
        end
    end

endmodule

// File: tb/tb_seg_led_apb.sv
// Directed testbench for seg_led_apb using a small scan divider.
module tb_seg_led_apb;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [4:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic [5:0]  seg_sel_n;
    logic [7:0]  seg_data;

    int checks = 0;
    int errors = 0;

    seg_led_apb #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
        .seg_sel_n(seg_sel_n), .seg_data(seg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the edge that performed the write
    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
        psel = 1'b1; pwrite = 1'b0; paddr = a;
        #1;
        check(tag, prdata, exp);
        psel = 1'b0;
        #1;
    endtask

    // Digit d must be lit with pattern seg for n consecutive cycles
    task automatic expect_digit(input int d, input logic [7:0] seg, input int n);
        logic [5:0] sel;
        sel = ~(6'b000001 << d);
        for (int k = 0; k < n; k++) begin
            check($sformatf("dig%0d_sel_c%0d", d, k), {26'd0, seg_sel_n}, {26'd0, sel});
            check($sformatf("dig%0d_seg_c%0d", d, k), {24'd0, seg_data}, {24'd0, seg});
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // Reset
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        check("rst_sel", {26'd0, seg_sel_n}, 32'h3F);
        check("rst_seg", {24'd0, seg_data}, 32'hFF);
        check("rst_prdata", prdata, 32'h0);

        // Register write and readback, reserved space
        apb_write(5'd0, 32'h1);
        apb_write(5'd1, 32'hA);
        apb_read("rd_dig0", 5'd0, 32'h1);
        apb_read("rd_dig1", 5'd1, 32'hA);
        apb_read("rd_resv10", 5'h10, 32'h0);
        apb_write(5'd7, 32'hFFFF_FFFF);
        apb_read("rd_resv07", 5'd7, 32'h0);
        apb_read("rd_ctrl0", 5'd6, 32'h0);
        paddr = 5'd0; #1;
        check("prdata_nosel", prdata, 32'h0);

        // Enable: blank on the write edge, digit 0 from the following edge
        apb_write(5'd6, 32'h1);
        check("en_lat_sel", {26'd0, seg_sel_n}, 32'h3F);
        apb_read("rd_ctrl1", 5'd6, 32'h1);
        @(posedge clk); #1;
        expect_digit(0, 8'hF9, SD);
        expect_digit(1, 8'h88, 2);

        // Disable mid-scan blanks on the following edge
        apb_write(5'd6, 32'h0);
        @(posedge clk); #1;
        check("dis_sel", {26'd0, seg_sel_n}, 32'h3F);
        check("dis_seg", {24'd0, seg_data}, 32'hFF);

        // Full six-digit frame, restart at digit 0, wrap 5 -> 0
        apb_write(5'd1, 32'h2);
        apb_write(5'd2, 32'h3);
        apb_write(5'd3, 32'h4);
        apb_write(5'd4, 32'hA);
        apb_write(5'd5, 32'hF);
        apb_write(5'd6, 32'h1);
        @(posedge clk); #1;
        expect_digit(0, 8'hF9, SD);
        expect_digit(1, 8'hA4, SD);
        expect_digit(2, 8'hB0, SD);
        expect_digit(3, 8'h99, SD);
        expect_digit(4, 8'h88, SD);
        expect_digit(5, 8'h8E, SD);
        expect_digit(0, 8'hF9, 2);

        // Decimal point handling on digit 2
        apb_write(5'd6, 32'h0);
        apb_write(5'd2, 32'h13);
`ifdef SEG_LED_DP_EN
        apb_read("rd_dig2_dp", 5'd2, 32'h13);
`else
        apb_read("rd_dig2_dp", 5'd2, 32'h3);
`endif
        apb_write(5'd6, 32'h1);
        @(posedge clk); #1;
        expect_digit(0, 8'hF9, SD);
        expect_digit(1, 8'hA4, SD);
`ifdef SEG_LED_DP_EN
        expect_digit(2, 8'h30, SD);
`else
        expect_digit(2, 8'hB0, SD);
`endif
        // Live digit update while digit 3 is displayed
        expect_digit(3, 8'h99, 1);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b1; paddr = 5'd3; pwdata = 32'h8;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        check("live_old_seg", {24'd0, seg_data}, 32'h99);
        @(posedge clk); #1;
        check("live_new_seg", {24'd0, seg_data}, 32'h80);
        check("live_sel", {26'd0, seg_sel_n}, 32'h37);
        @(posedge clk); #1;
        expect_digit(4, 8'h88, 1);

        // Reset mid-scan blanks on the next edge and clears the registers
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_sel", {26'd0, seg_sel_n}, 32'h3F);
        check("rst_mid_seg", {24'd0, seg_data}, 32'hFF);
        rst_n = 1'b0;
        apb_read("rst_mid_dig0", 5'd0, 32'h0);
        apb_read("rst_mid_ctrl", 5'd6, 32'h0);
        @(posedge clk); #1;
        check("rst_mid_hold", {26'd0, seg_sel_n}, 32'h3F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_led_apb.md
# seg_led_apb

APB-attached controller for a six-digit, common-anode, multiplexed seven-segment display (module `seg_led`). Software writes one hex digit per display position plus a scan-enable bit. The block decodes each digit, time-multiplexes the six positions onto the shared segment bus, and drives active-low digit selects. It sits on the peripheral APB bus of the SoC, clocked by the 50 MHz system clock.

## Interface
- `SCAN_DIV`, default 5000: clock cycles each digit stays lit (100 µs at 50 MHz; 600 µs per full frame). Minimum 2.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-high (asserted when 1).
- `psel` in 1: APB select.
- `penable` in 1: APB access phase.
- `paddr` in 5: register index (not a byte address).
- `pwrite` in 1: 1 = write, 0 = read.
- `pwdata` in 32: write data.
- `prdata` out 32: read data (combinational).
- `seg_sel_n` out 6: active-low one-hot digit select; bit i enables digit i.
- `seg_data` out 8: active-low segments ordered {dp, g, f, e, d, c, b, a}.

## Operation
- Registers (index : name : fields):
  - 0x00–0x05 : DIGITn : bits[3:0] hex value; bit[4] decimal point. Bits[7:5] stored, ignored by decode.
  - 0x06 : CTRL : bit[0] scan enable.
  - 0x07–0x1F : reserved. Writes are ignored; reads return 0.
- Write: registers update on the rising edge where `psel & penable & pwrite`. DIGITn stores `pwdata[7:0]`; CTRL stores `pwdata[0]`.
- Read: `prdata` = zero-extended register contents when `psel & ~pwrite`; otherwise 0. No wait states. There are no pready/pslverr ports.
- Decode (active-high {g..a}, before inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- `seg_data` = ~{dp, pattern}.
- Scan: a counter runs 0..SCAN_DIV-1. On terminal count, the digit index advances 0→1→…→5→0.
- While CTRL[0]=0: counter and index are held at 0; `seg_sel_n`=6'b111111 and `seg_data`=8'hFF (blank).

## Timing
- Reset values: all DIGITn=0, CTRL=0, counter=0, index=0, `seg_sel_n`=6'b111111, `seg_data`=8'hFF. `prdata` is 0 whenever `psel`=0.
- Reset asserted mid-scan blanks the outputs on the next edge.
- `seg_sel_n` and `seg_data` are registered. They reflect the current index and the current DIGIT contents with one cycle of latency.
- Enable: on the edge that writes CTRL[0]=1, CTRL updates. On the following edge, the outputs show digit 0 (`seg_sel_n`=6'b111110). Each digit is held for exactly SCAN_DIV cycles.
- Disable: the edge after CTRL[0] becomes 0 blanks the outputs and clears the counter and index. Re-enabling restarts at digit 0.
- Writing DIGITn while digit n is displayed changes `seg_data` one cycle after the register updates. There is no glitch and the scan position is unaffected.
- Wrap: after digit 5 completes its SCAN_DIV cycles, digit 0 follows with no blank gap.
- Exactly one `seg_sel_n` bit is low while enabled.

## Configuration
- `SEG_LED_DP_EN` defined: DIGITn bit[4] drives the dp segment (`seg_data[7]` = ~bit4).
- Macro undefined: dp is hard off (`seg_data[7]`=1). Bit[4] is not stored and reads as 0, so DIGITn readback is bits[3:0] only. All other behaviour is identical.

## Test plan
- Reset, `psel`=0 → `seg_sel_n`=6'b111111, `seg_data`=8'hFF, `prdata`=0.
- Write DIGIT0=0x1, DIGIT1=0xA; read back → 0x00000001 and 0x0000000A. Read index 0x10 → 0.
- Write CTRL=1 with DIGIT0=0x1, DIGIT1=0xA → digit 0 shows `seg_data`=8'hF9 for SCAN_DIV cycles, then `seg_sel_n`=6'b111101 with `seg_data`=8'h88.
- Load DIGIT0–5 = 1, 2, 3, 4, A, F and enable → full 6-digit sequence with correct patterns. The select wraps 5→0 after 6×SCAN_DIV cycles.
- Mid-scan CTRL=0 → blank (6'b111111 / 8'hFF) on the next edge. Re-enable restarts at digit 0.
- With `SEG_LED_DP_EN`: DIGIT2=0x13 → `seg_data`=8'h30 while digit 2 is lit. Without the macro → 8'hB0, and readback is 0x3.
